// File: rtl/ir_pair_sequencer_pkg.sv
// Shared types and constants for the IR mark/space pair sequencer.
package ir_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CARRIER,
        F0,
        F1,
        F2,
        F3,
        MARK_START,
        MARK_GUARD,
        MARK_WAIT,
        SPACE_START,
        SPACE_GUARD,
        SPACE_WAIT,
        NEXT,
        FINISH
    } state_t;

    localparam int PAIR_BYTES    = 4;
    localparam int START_LATENCY = 6;

endpackage

// File: rtl/ir_pair_sequencer.sv
// Plays one IR burst: loads the PWM carrier, then fetches 4-byte mark/space pairs
// from the code ROM and gates the carrier while the delay timer runs each duration.
module ir_pair_sequencer
    import ir_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = 13,
    parameter int PWM_WIDTH   = 8,
    parameter int DELAY_WIDTH = 16
) (
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic                   start_in,
    input  logic                   abort_in,
    input  logic [ADDR_WIDTH-1:0]  base_addr_in,
    input  logic [7:0]             pair_count_in,
    input  logic [PWM_WIDTH-1:0]   carrier_in,
    output logic                   busy_out,
    output logic                   done_out,
    output logic [ADDR_WIDTH-1:0]  mem_address_out,
    input  logic [7:0]             mem_data_in,
    output logic                   pwm_enable_out,
    output logic                   pwm_forced_out,
    output logic                   pwm_wr_strobe_out,
    output logic [PWM_WIDTH-1:0]   pwm_value_out,
    output logic                   delay_enable_out,
    output logic                   delay_start_strobe_out,
    output logic [DELAY_WIDTH-1:0] delay_value_out,
    input  logic                   delay_busy_in
);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [7:0]             remain_q, remain_d;
    logic [PWM_WIDTH-1:0]   carrier_q, carrier_d;
    logic [31:0]            pair_q, pair_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pwm_en_q, pwm_en_d;
    logic                   pwm_wr_q, pwm_wr_d;
    logic [PWM_WIDTH-1:0]   pwm_val_q, pwm_val_d;
    logic                   dly_strobe_q, dly_strobe_d;
    logic [DELAY_WIDTH-1:0] dly_val_q, dly_val_d;

    logic [31:0] pair_shift;
    logic [15:0] mark;
    logic [15:0] space;

    // Bytes arrive big-endian: mark_hi, mark_lo, space_hi, space_lo.
    assign pair_shift = {pair_q[23:0], mem_data_in};
    assign mark       = pair_q[31:16];
    assign space      = pair_q[15:0];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        remain_d     = remain_q;
        carrier_d    = carrier_q;
        pair_d       = pair_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pwm_en_d     = 1'b0;
        pwm_wr_d     = 1'b0;
        pwm_val_d    = pwm_val_q;
        dly_strobe_d = 1'b0;
        dly_val_d    = dly_val_q;

        if (state_q != IDLE && abort_in) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                    if (start_in && !abort_in) begin
                        ptr_d     = base_addr_in;
                        remain_d  = pair_count_in;
                        carrier_d = carrier_in;
                        busy_d    = 1'b1;
                        state_d   = (pair_count_in == 8'd0) ? FINISH : CARRIER;
                    end
                end
                CARRIER: begin
                    pwm_wr_d  = 1'b1;
                    pwm_val_d = carrier_q;
                    state_d   = F0;
                end
                F0, F1, F2, F3: begin
                    pair_d = pair_shift;
                    ptr_d  = ptr_q + 1'b1;
                    case (state_q)
                        F0:      state_d = F1;
                        F1:      state_d = F2;
                        F2:      state_d = F3;
                        default: state_d = MARK_START;
                    endcase
                end
                MARK_START: begin
                    if (mark == 16'd0) begin
                        state_d = SPACE_START;
                    end else begin
                        pwm_en_d     = 1'b1;
                        dly_strobe_d = 1'b1;
                        dly_val_d    = DELAY_WIDTH'(mark);
                        state_d      = MARK_GUARD;
                    end
                end
                // The timer only reports busy one cycle after its start strobe.
                MARK_GUARD: begin
                    pwm_en_d = 1'b1;
                    state_d  = MARK_WAIT;
                end
                MARK_WAIT: begin
                    if (delay_busy_in) begin
                        pwm_en_d = 1'b1;
                    end else begin
                        state_d = SPACE_START;
                    end
                end
                SPACE_START: begin
                    if (space == 16'd0) begin
                        state_d = NEXT;
                    end else begin
                        dly_strobe_d = 1'b1;
                        dly_val_d    = DELAY_WIDTH'(space);
                        state_d      = SPACE_GUARD;
                    end
                end
                SPACE_GUARD: state_d = SPACE_WAIT;
                SPACE_WAIT: begin
                    if (!delay_busy_in) begin
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    remain_d = remain_q - 8'd1;
                    state_d  = (remain_q == 8'd1) ? FINISH : F0;
                end
                FINISH: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            remain_q     <= '0;
            carrier_q    <= '0;
            pair_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pwm_en_q     <= 1'b0;
            pwm_wr_q     <= 1'b0;
            pwm_val_q    <= '0;
            dly_strobe_q <= 1'b0;
            dly_val_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            remain_q     <= remain_d;
            carrier_q    <= carrier_d;
            pair_q       <= pair_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pwm_en_q     <= pwm_en_d;
            pwm_wr_q     <= pwm_wr_d;
            pwm_val_q    <= pwm_val_d;
            dly_strobe_q <= dly_strobe_d;
            dly_val_q    <= dly_val_d;
        end
    end

    assign busy_out               = busy_q;
    assign done_out               = done_q;
    assign mem_address_out        = ptr_q;
    assign pwm_enable_out         = pwm_en_q;
    assign pwm_forced_out         = 1'b0;
    assign pwm_wr_strobe_out      = pwm_wr_q;
    assign pwm_value_out          = pwm_val_q;
    assign delay_enable_out       = busy_q;
    assign delay_start_strobe_out = dly_strobe_q;
    assign delay_value_out        = dly_val_q;

endmodule

// File: tb/tb_ir_pair_sequencer.sv
// Directed bench for ir_pair_sequencer with a ROM array and a cycle-counting delay timer model.
module tb_ir_pair_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [12:0] base = '0;
    logic [7:0]  count = '0;
    logic [7:0]  carrier = '0;
    logic        busy, done, pwm_en, pwm_forced, pwm_wr, dly_en, dly_strobe, dly_busy;
    logic [12:0] addr;
    logic [7:0]  mdata;
    logic [7:0]  pwm_val;
    logic [15:0] dly_val;
    logic [15:0] tcnt;
    logic [7:0]  rom [0:8191];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ir_pair_sequencer #(.ADDR_WIDTH(13), .PWM_WIDTH(8), .DELAY_WIDTH(16)) dut (
        .clock_in(clk), .reset_n_in(rst_n), .start_in(start), .abort_in(abort),
        .base_addr_in(base), .pair_count_in(count), .carrier_in(carrier),
        .busy_out(busy), .done_out(done), .mem_address_out(addr), .mem_data_in(mdata),
        .pwm_enable_out(pwm_en), .pwm_forced_out(pwm_forced), .pwm_wr_strobe_out(pwm_wr),
        .pwm_value_out(pwm_val), .delay_enable_out(dly_en),
        .delay_start_strobe_out(dly_strobe), .delay_value_out(dly_val),
        .delay_busy_in(dly_busy)
    );

    assign mdata = rom[addr];

    // Delay timer: loads on strobe, counts down one unit per clock, busy while nonzero.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt <= '0;
        else if (!dly_en) tcnt <= '0;
        else if (dly_strobe) tcnt <= dly_val;
        else if (tcnt != 0) tcnt <= tcnt - 16'd1;
    end
    assign dly_busy = (tcnt != 16'd0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input logic [12:0] a, input logic [15:0] m, input logic [15:0] s);
        rom[a]         = m[15:8];
        rom[a + 13'd1] = m[7:0];
        rom[a + 13'd2] = s[15:8];
        rom[a + 13'd3] = s[7:0];
    endtask

    // Leaves the bench sampling the first cycle after the accepting edge (k = 0).
    task automatic start_burst(input logic [12:0] b, input logic [7:0] n, input logic [7:0] c);
        base = b; count = n; carrier = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++;
        if ({busy, done, addr, pwm_en, pwm_forced, pwm_wr, pwm_val, dly_en, dly_strobe, dly_val} !== '0) begin
            errors++; $display("FAIL reset_outputs got busy=%0b done=%0b addr=%h en=%0b wr=%0b", busy, done, addr, pwm_en, pwm_wr);
        end
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %0b exp 0", busy); end
    endtask

    task automatic test_single_pair(input string tag);
        int en_cnt = 0, en_first = -1, str_cnt = 0, done_k = -1, done_n = 0;
        set_pair(13'h0100, 16'd5, 16'd3);
        start_burst(13'h0100, 8'd1, 8'h1A);
        for (int k = 0; k <= 26; k++) begin
            if (k > 0) tick();
            if (pwm_en) begin en_cnt++; if (en_first < 0) en_first = k; end
            if (dly_strobe) str_cnt++;
            if (done) begin done_n++; if (done_k < 0) done_k = k; end
            if (k == 0) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_rise got %0b exp 1", tag, busy); end
            end
            if (k == 1) begin
                checks++;
                if (pwm_wr !== 1'b1 || pwm_val !== 8'h1A) begin
                    errors++; $display("FAIL %s_carrier got wr=%0b val=%h exp wr=1 val=1a", tag, pwm_wr, pwm_val);
                end
            end
            if (k == 2) begin
                checks++;
                if (pwm_wr !== 1'b0) begin errors++; $display("FAIL %s_wr_once got %0b exp 0", tag, pwm_wr); end
            end
            if (k >= 1 && k <= 4) begin
                checks++;
                if (addr !== 13'h0100 + 13'(k - 1)) begin
                    errors++; $display("FAIL %s_addr_k%0d got %h exp %h", tag, k, addr, 13'h0100 + 13'(k - 1));
                end
            end
            if (k == 6) begin
                checks++;
                if (dly_strobe !== 1'b1 || dly_val !== 16'd5) begin
                    errors++; $display("FAIL %s_mark_strobe got s=%0b v=%0d exp s=1 v=5", tag, dly_strobe, dly_val);
                end
            end
            if (k == 14) begin
                checks++;
                if (dly_strobe !== 1'b1 || dly_val !== 16'd3 || pwm_en !== 1'b0) begin
                    errors++; $display("FAIL %s_space_strobe got s=%0b v=%0d en=%0b exp s=1 v=3 en=0", tag, dly_strobe, dly_val, pwm_en);
                end
            end
            if (k == 20) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_hold got %0b exp 1", tag, busy); end
            end
            if (k == 21) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_fall got %0b exp 0", tag, busy); end
            end
            // Start and input changes while busy must be ignored.
            if (k == 3) begin start = 1'b1; base = 13'h0555; carrier = 8'h77; count = 8'd3; end
            if (k == 8) start = 1'b0;
        end
        checks++;
        if (en_first !== 6 || en_cnt !== 7) begin
            errors++; $display("FAIL %s_enable_window got first=%0d len=%0d exp first=6 len=7", tag, en_first, en_cnt);
        end
        checks++;
        if (str_cnt !== 2) begin errors++; $display("FAIL %s_strobe_count got %0d exp 2", tag, str_cnt); end
        checks++;
        if (done_k !== 21 || done_n !== 1) begin
            errors++; $display("FAIL %s_done got k=%0d n=%0d exp k=21 n=1", tag, done_k, done_n);
        end
    endtask

    task automatic test_zero_count();
        int act = 0;
        start_burst(13'h0300, 8'd0, 8'h55);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zc_k0 got busy=%0b done=%0b exp 1 0", busy, done); end
        if (pwm_wr || dly_strobe || pwm_en) act++;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL zc_k1 got busy=%0b done=%0b exp 0 1", busy, done); end
        if (pwm_wr || dly_strobe || pwm_en) act++;
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL zc_done_once got %0b exp 0", done); end
        if (pwm_wr || dly_strobe || pwm_en) act++;
        checks++;
        if (act !== 0) begin errors++; $display("FAIL zc_no_activity got %0d active cycles exp 0", act); end
    endtask

    task automatic test_zero_mark();
        int str_cnt = 0, en_seen = 0, done_k = -1;
        logic [15:0] last_val = '0;
        set_pair(13'h0200, 16'd0, 16'd4);
        start_burst(13'h0200, 8'd1, 8'h22);
        for (int k = 0; k < 60 && done_k < 0; k++) begin
            if (k > 0) tick();
            if (pwm_en) en_seen++;
            if (dly_strobe) begin str_cnt++; last_val = dly_val; end
            if (done) done_k = k;
        end
        checks++;
        if (str_cnt !== 1 || last_val !== 16'd4) begin
            errors++; $display("FAIL zm_strobe got n=%0d v=%0d exp n=1 v=4", str_cnt, last_val);
        end
        checks++;
        if (en_seen !== 0) begin errors++; $display("FAIL zm_enable got %0d high cycles exp 0", en_seen); end
        checks++;
        if (done_k !== 15) begin errors++; $display("FAIL zm_done_cycle got %0d exp 15", done_k); end
    endtask

    task automatic test_wrap();
        logic [12:0] seen [0:15];
        logic [12:0] exp_a [0:8];
        logic [15:0] vals [0:7];
        logic [12:0] prev;
        int n_seen = 0, n_str = 0, done_n = 0, done_k = -1;
        exp_a = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001, 13'h0002, 13'h0003, 13'h0004, 13'h0005, 13'h0006};
        set_pair(13'h1FFE, 16'd1, 16'd1);
        set_pair(13'h0002, 16'd2, 16'd1);
        start_burst(13'h1FFE, 8'd2, 8'h10);
        prev = addr; seen[0] = addr; n_seen = 1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) tick();
            if (addr !== prev && n_seen < 16) begin seen[n_seen] = addr; n_seen++; prev = addr; end
            if (dly_strobe && n_str < 8) begin vals[n_str] = dly_val; n_str++; end
            if (done) begin done_n++; if (done_k < 0) done_k = k; end
        end
        checks++;
        if (n_seen !== 9) begin errors++; $display("FAIL wrap_addr_count got %0d exp 9", n_seen); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i >= n_seen || seen[i] !== exp_a[i]) begin
                errors++; $display("FAIL wrap_addr_%0d got %h exp %h", i, (i < n_seen) ? seen[i] : 13'h0, exp_a[i]);
            end
        end
        checks++;
        if (n_str !== 4 || vals[0] !== 16'd1 || vals[1] !== 16'd1 || vals[2] !== 16'd2 || vals[3] !== 16'd1) begin
            errors++; $display("FAIL wrap_strobes got n=%0d exp 4 values 1,1,2,1", n_str);
        end
        checks++;
        if (done_n !== 1 || done_k !== 29) begin
            errors++; $display("FAIL wrap_done got n=%0d k=%0d exp n=1 k=29", done_n, done_k);
        end
    endtask

    task automatic test_abort();
        int bad = 0;
        set_pair(13'h0400, 16'd32, 16'd3);
        start_burst(13'h0400, 8'd1, 8'h33);
        for (int k = 1; k <= 9; k++) tick();
        checks++;
        if (pwm_en !== 1'b1) begin errors++; $display("FAIL abort_pre_en got %0b exp 1", pwm_en); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (pwm_en !== 1'b0 || busy !== 1'b0 || dly_en !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_stop got en=%0b busy=%0b dly_en=%0b done=%0b exp 0 0 0 0", pwm_en, busy, dly_en, done);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done || pwm_en || busy || dly_strobe) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles exp 0", bad); end
        test_single_pair("after_abort");
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1; abort = 1'b1; base = 13'h0100; count = 8'd1; carrier = 8'h44;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy got %0b exp 0", busy); end
        tick();
        checks++;
        if (pwm_wr !== 1'b0) begin errors++; $display("FAIL start_abort_wr got %0b exp 0", pwm_wr); end
    endtask

    task automatic test_async_reset();
        start_burst(13'h0100, 8'd1, 8'h1A);
        for (int k = 1; k <= 16; k++) tick();
        checks++;
        if (busy !== 1'b1 || pwm_en !== 1'b0) begin
            errors++; $display("FAIL ar_space_wait got busy=%0b en=%0b exp 1 0", busy, pwm_en);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, addr, pwm_en, pwm_forced, pwm_wr, pwm_val, dly_en, dly_strobe, dly_val} !== '0) begin
            errors++; $display("FAIL ar_outputs got busy=%0b addr=%h val=%h dval=%0d exp all 0", busy, addr, pwm_val, dly_val);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ar_idle got busy=%0b done=%0b exp 0 0", busy, done); end
        test_single_pair("after_reset");
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) rom[i] = 8'h00;
        test_reset();
        test_single_pair("single");
        test_zero_count();
        test_zero_mark();
        test_wrap();
        test_abort();
        test_start_abort_idle();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_pair_sequencer.md
Name: ir_pair_sequencer

Overview:
- Plays one IR code burst.
- Programs the PWM generator with a carrier compare value, then walks a list of mark/space duration pairs in the code ROM.
- Per pair: gates the carrier on for the mark and off for the space, timing each with the delay timer.
- Sits between the top-level controller (which selects the code and starts it) and the shared pwm_generator, delay_timer and tv_codes_rom.

Parameters:
- ADDR_WIDTH, 13, ROM byte-address width.
- PWM_WIDTH, 8, PWM compare value width.
- DELAY_WIDTH, 16, delay timer value width; must equal 16, because one duration is 2 ROM bytes.

Ports:
- clock_in  in  1  clock
- reset_n_in  in  1  reset, asynchronous, active-low
- start_in  in  1  start request, sampled in IDLE only
- abort_in  in  1  stop current burst
- base_addr_in  in  ADDR_WIDTH  first byte of pair list, latched at start
- pair_count_in  in  8  number of pairs, latched at start
- carrier_in  in  PWM_WIDTH  carrier compare value, latched at start
- busy_out  in/out: out  1  high from accepted start until return to IDLE
- done_out  out  1  one-cycle pulse on normal completion
- mem_address_out  out  ADDR_WIDTH  ROM address
- mem_data_in  in  8  ROM data, combinational from mem_address_out
- pwm_enable_out  out  1  carrier gate
- pwm_forced_out  out  1  idle level of PWM output, constant 0
- pwm_wr_strobe_out  out  1  load pwm_value_out
- pwm_value_out  out  PWM_WIDTH  carrier compare value
- delay_enable_out  out  1  timer enable, equals busy_out
- delay_start_strobe_out  out  1  load and start delay timer
- delay_value_out  out  DELAY_WIDTH  duration in timer units
- delay_busy_in  in  1  timer still counting

Behaviour:
Registers and reset:
- All outputs are registered.
- Asynchronous reset (reset_n_in low) forces state IDLE and drives every output to 0 immediately. This applies mid-burst as well; no done_out is produced.

ROM pair format:
- 4 bytes per pair: mark_hi, mark_lo, space_hi, space_lo (big-endian 16-bit).
- The address pointer increments modulo 2^ADDR_WIDTH; wrap-around is legal.

States:
- IDLE: if start_in, latch inputs and go to CARRIER; busy_out rises the next cycle. If the latched pair_count is 0, go to FINISH instead.
- CARRIER: pwm_wr_strobe_out=1 for exactly 1 cycle, pwm_value_out=carrier. Then go to F0.
- F0..F3: one byte per cycle. mem_address_out=ptr, capture mem_data_in, ptr++. This takes 4 cycles; the carrier is off throughout.
- MARK_START:
  - If mark==0, go to SPACE_START.
  - Otherwise pwm_enable_out=1, delay_start_strobe_out=1 (1 cycle), delay_value_out=mark, then go to MARK_GUARD.
- MARK_GUARD: pwm_enable_out=1; delay_busy_in is ignored this one cycle. Go to MARK_WAIT.
- MARK_WAIT: pwm_enable_out=1 until delay_busy_in==0, then go to SPACE_START. pwm_enable_out falls the same edge.
- SPACE_START / SPACE_GUARD / SPACE_WAIT: same as the mark states with pwm_enable_out=0. A zero space skips directly to NEXT.
- NEXT: decrement the remaining count. If 0, go to FINISH; else go to F0.
- FINISH: done_out=1 for 1 cycle, busy_out=0 next cycle, go to IDLE.

Latency and overhead:
- Start to first mark enable: 6 cycles (CARRIER + F0..F3 + MARK_START registered).
- Inter-pair overhead: 5 off-cycles (NEXT + F0..F3) appended to each space. This is accepted and absorbed in the ROM timings.

Abort and boundary cases:
- abort_in high in any non-IDLE state: next edge goes to IDLE. pwm_enable_out=0, all strobes 0, done_out not pulsed. abort_in has priority over all other transitions.
- start_in while busy is ignored. start_in and abort_in both high in IDLE: start is ignored.
- Inputs changing after start do not affect the running burst.
- delay_busy_in already low in a WAIT state (after the guard cycle) advances immediately.

Decomposition:
- Package ir_seq_pkg holds:
  - enum state_t (IDLE, CARRIER, F0, F1, F2, F3, MARK_START, MARK_GUARD, MARK_WAIT, SPACE_START, SPACE_GUARD, SPACE_WAIT, NEXT, FINISH).
  - localparam PAIR_BYTES=4.
  - localparam START_LATENCY=6.
- Single module; no sub-module. The byte assembly is a 32-bit shift register inside the block.

Test Plan:
- base=0x0100, count=1, carrier=0x1A, ROM {00 05 00 03}:
  - pwm_wr_strobe_out with value 0x1A one cycle after start.
  - pwm_enable_out high from cycle 6, through the mark, until the timer (5 units) drops busy.
  - Space of 3 units with enable low, then done_out pulse; addresses 0x0100..0x0103 seen.
- count=0:
  - busy_out high 1 cycle, done_out pulse, no pwm/delay strobes.
- Pair {00 00 00 04}:
  - No mark strobe, pwm_enable_out never high, exactly one delay strobe with value 4.
- base=0x1FFE, count=2:
  - Address sequence 1FFE, 1FFF, 0000, 0001, then 0002..0005; two done-free pair cycles then a single done_out.
- abort_in asserted mid MARK_WAIT:
  - Next cycle pwm_enable_out=0, busy_out=0, no done_out; new start then behaves normally.
- reset_n_in low mid SPACE_WAIT (asynchronous, between edges):
  - All outputs 0 immediately; start after release replays from CARRIER.
